// File: rtl/display_pkg.sv
// Shared types and position codes for the display frame generator.
package display_pkg;

    localparam int CODE_W = 6;

    localparam logic [CODE_W-1:0] BLANK_CODE      = 6'h3F;
    localparam logic [CODE_W-1:0] ALARM_MARK_CODE = 6'h0A;

    typedef enum logic [1:0] {
        NORMAL_STATE        = 2'd0,
        TIME_SETTING_STATE  = 2'd1,
        ALARM_SETTING_STATE = 2'd2
    } state_t;

    // A BCD digit is shown as its own value in the low nibble.
    function automatic logic [CODE_W-1:0] digit_code(input logic [3:0] d);
        return {2'b00, d};
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink half-period timer: counts 0..BLINK_DIV-1 and toggles phase on wrap.
// restart forces count and phase back to zero on the next edge.
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] count;

    // Half-period counter with phase toggle on wrap; reset/restart clear both.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_frame_generator.sv
// Display frame generator: builds a registered per-position code word for
// DIGITS time digits plus two status positions, with cursor and ringing blink.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero top digit in NORMAL and
// ALARM_SET modes.
module display_frame_generator
    import display_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int ALARMS    = 4,
    parameter int BLINK_DIV = 25_000_000,
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int VW = (ALARMS > 1) ? $clog2(ALARMS) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  state_t                            state,
    input  logic [PW-1:0]                     h_ptr,
    input  logic [VW-1:0]                     v_ptr,
    input  logic [DIGITS*4-1:0]               time_data,
    input  logic [ALARMS*DIGITS*4-1:0]        alarm_data,
    input  logic [ALARMS-1:0]                 is_activated,
    input  logic                              ringing,
    output logic [(DIGITS+2)*CODE_W-1:0]      display_code,
    output logic                              blink_phase
);

    localparam int TOP = DIGITS - 1;

    state_t        prev_state;
    logic [PW-1:0] prev_h;
    logic [VW-1:0] prev_v;
    logic          prev_ringing;
    logic          restart;
    logic          hidden;

    logic [DIGITS*4-1:0]             sel_alarm;
    logic                            v_ok;
    logic                            act_sel;
    logic [(DIGITS+2)*CODE_W-1:0]    next_code;

    // Any cursor/mode change or a new ring starts a fresh visible half-period.
    assign restart = (state != prev_state) || (h_ptr != prev_h) ||
                     (v_ptr != prev_v) || (ringing && !prev_ringing);

    // On a restart the frame is built as visible, matching the cleared phase.
    assign hidden = blink_phase && !restart;

    // Remember last-cycle inputs for change detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_state   <= NORMAL_STATE;
            prev_h       <= '0;
            prev_v       <= '0;
            prev_ringing <= 1'b0;
        end else begin
            prev_state   <= state;
            prev_h       <= h_ptr;
            prev_v       <= v_ptr;
            prev_ringing <= ringing;
        end
    end

    blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .phase   (blink_phase)
    );

    // Pick the alarm slot addressed by v_ptr; out-of-range leaves v_ok low.
    always_comb begin
        sel_alarm = '0;
        v_ok      = 1'b0;
        act_sel   = 1'b0;
        for (int a = 0; a < ALARMS; a++) begin
            if (v_ptr == VW'(a)) begin
                sel_alarm = alarm_data[a*DIGITS*4 +: DIGITS*4];
                v_ok      = 1'b1;
                act_sel   = is_activated[a];
            end
        end
    end

    // Build the next frame; every position defaults to blank.
    always_comb begin
        next_code = {(DIGITS+2){BLANK_CODE}};
        case (state)
            NORMAL_STATE: begin
                if (!(ringing && hidden)) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        next_code[i*CODE_W +: CODE_W] = digit_code(time_data[i*4 +: 4]);
                    end
`ifdef LEADING_ZERO_BLANK_EN
                    if (time_data[TOP*4 +: 4] == 4'd0) begin
                        next_code[TOP*CODE_W +: CODE_W] = BLANK_CODE;
                    end
`endif
                    next_code[(DIGITS+1)*CODE_W +: CODE_W] =
                        (|is_activated) ? ALARM_MARK_CODE : BLANK_CODE;
                end
            end
            TIME_SETTING_STATE: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (hidden && (h_ptr == PW'(i))) begin
                        next_code[i*CODE_W +: CODE_W] = BLANK_CODE;
                    end else begin
                        next_code[i*CODE_W +: CODE_W] = digit_code(time_data[i*4 +: 4]);
                    end
                end
            end
            ALARM_SETTING_STATE: begin
                if (v_ok) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        next_code[i*CODE_W +: CODE_W] = digit_code(sel_alarm[i*4 +: 4]);
                    end
`ifdef LEADING_ZERO_BLANK_EN
                    if (sel_alarm[TOP*4 +: 4] == 4'd0) begin
                        next_code[TOP*CODE_W +: CODE_W] = BLANK_CODE;
                    end
`endif
                    for (int i = 0; i < DIGITS; i++) begin
                        if (hidden && (h_ptr == PW'(i))) begin
                            next_code[i*CODE_W +: CODE_W] = BLANK_CODE;
                        end
                    end
                    next_code[DIGITS*CODE_W +: CODE_W] = CODE_W'(v_ptr);
                    next_code[(DIGITS+1)*CODE_W +: CODE_W] =
                        act_sel ? ALARM_MARK_CODE : BLANK_CODE;
                end
            end
            default: begin
                next_code = {(DIGITS+2){BLANK_CODE}};
            end
        endcase
    end

    // Register the frame; reset shows an all-blank display.
    always_ff @(posedge clock) begin
        if (reset) begin
            display_code <= {(DIGITS+2){BLANK_CODE}};
        end else begin
            display_code <= next_code;
        end
    end

endmodule

// File: tb/tb_display_frame_generator.sv
// Self-checking bench for display_frame_generator (DIGITS=6, ALARMS=4,
// BLINK_DIV=4) plus a second instance with ALARMS=3 for out-of-range v_ptr.
module tb_display_frame_generator;
    import display_pkg::*;

    localparam int DIGITS = 6;
    localparam int ALARMS = 4;
    localparam int BDIV   = 4;
    localparam logic [47:0] ALL_BLANK = {8{6'h3F}};

    logic         clock;
    logic         reset;
    state_t       state;
    logic [2:0]   h_ptr;
    logic [1:0]   v_ptr;
    logic [23:0]  time_data;
    logic [95:0]  alarm_data;
    logic [3:0]   is_activated;
    logic         ringing;
    logic [47:0]  display_code;
    logic         blink_phase;
    logic [47:0]  code3;
    logic         phase3;

    int t_dig [DIGITS];
    int a_dig [ALARMS][DIGITS];

    // model state: cycles since the last restart/reset and last-seen inputs
    int     k;
    state_t m_state;
    int     m_h, m_v, m_ring;
    logic [47:0] exp_code, exp_code3;
    logic        exp_phase;

    int n_checks = 0;
    int n_pass   = 0;

    display_frame_generator #(.DIGITS(DIGITS), .ALARMS(ALARMS), .BLINK_DIV(BDIV)) dut (
        .clock(clock), .reset(reset), .state(state), .h_ptr(h_ptr), .v_ptr(v_ptr),
        .time_data(time_data), .alarm_data(alarm_data), .is_activated(is_activated),
        .ringing(ringing), .display_code(display_code), .blink_phase(blink_phase)
    );

    display_frame_generator #(.DIGITS(DIGITS), .ALARMS(3), .BLINK_DIV(BDIV)) dut3 (
        .clock(clock), .reset(reset), .state(state), .h_ptr(h_ptr), .v_ptr(v_ptr),
        .time_data(time_data), .alarm_data(alarm_data[71:0]), .is_activated(is_activated[2:0]),
        .ringing(ringing), .display_code(code3), .blink_phase(phase3)
    );

    // clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the packed data buses from the digit arrays.
    task automatic apply_data();
        for (int i = 0; i < DIGITS; i++) time_data[i*4 +: 4] = 4'(t_dig[i]);
        for (int a = 0; a < ALARMS; a++)
            for (int i = 0; i < DIGITS; i++)
                alarm_data[(a*DIGITS+i)*4 +: 4] = 4'(a_dig[a][i]);
    endtask

    // Reference frame from the mode rules, for an instance with nalarms slots.
    function automatic logic [47:0] model_frame(input int nalarms, input bit hid);
        logic [5:0] p [8];
        logic [47:0] r;
        int act;
        int hp;
        int vp;
        act = int'(is_activated) & ((1 << nalarms) - 1);
        hp  = int'(h_ptr);
        vp  = int'(v_ptr);
        for (int i = 0; i < 8; i++) p[i] = 6'h3F;
        if (state == NORMAL_STATE) begin
            if (!(ringing && hid)) begin
                for (int i = 0; i < DIGITS; i++) p[i] = 6'(t_dig[i]);
`ifdef LEADING_ZERO_BLANK_EN
                if (t_dig[DIGITS-1] == 0) p[DIGITS-1] = 6'h3F;
`endif
                p[7] = (act != 0) ? 6'h0A : 6'h3F;
            end
        end else if (state == TIME_SETTING_STATE) begin
            for (int i = 0; i < DIGITS; i++) p[i] = (hid && hp == i) ? 6'h3F : 6'(t_dig[i]);
        end else if (state == ALARM_SETTING_STATE && vp < nalarms) begin
            for (int i = 0; i < DIGITS; i++) p[i] = 6'(a_dig[vp][i]);
`ifdef LEADING_ZERO_BLANK_EN
            if (a_dig[vp][DIGITS-1] == 0) p[DIGITS-1] = 6'h3F;
`endif
            if (hid && hp < DIGITS) p[hp] = 6'h3F;
            p[6] = 6'(vp);
            p[7] = (((act >> vp) & 1) != 0) ? 6'h0A : 6'h3F;
        end
        for (int i = 0; i < 8; i++) r[i*6 +: 6] = p[i];
        return r;
    endfunction

    // scoreboard comparison
    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock, update the reference model, then compare.
    task automatic tick(input string tag);
        bit rst_now, restart, hid;
        @(posedge clock);
        rst_now = reset;
        if (rst_now) begin
            k = 0;
            m_state = NORMAL_STATE; m_h = 0; m_v = 0; m_ring = 0;
            exp_code = ALL_BLANK;
            exp_code3 = ALL_BLANK;
        end else begin
            restart = (state != m_state) || (int'(h_ptr) != m_h) || (int'(v_ptr) != m_v) ||
                      (ringing && m_ring == 0);
            hid = !restart && (((k / BDIV) % 2) == 1);
            exp_code  = model_frame(ALARMS, hid);
            exp_code3 = model_frame(3, hid);
            k = restart ? 0 : k + 1;
            m_state = state; m_h = int'(h_ptr); m_v = int'(v_ptr); m_ring = int'(ringing);
        end
        exp_phase = ((k / BDIV) % 2) == 1;
        #1;
        check({tag, "_code"}, display_code, exp_code);
        check({tag, "_code3"}, code3, exp_code3);
        check({tag, "_phase"}, {47'd0, blink_phase}, {47'd0, exp_phase});
    endtask

    // Tick until the model reports the hidden phase, with a cycle budget.
    task automatic wait_hidden(input string tag);
        int n;
        n = 0;
        while (!exp_phase && n < 3 * BDIV) begin
            tick(tag);
            n++;
        end
        n_checks++;
        assert (exp_phase == 1'b1) n_pass++;
        else $error("FAIL %s_wait observed=%0d expected=1", tag, exp_phase);
    endtask

    initial begin
        k = 0; m_state = NORMAL_STATE; m_h = 0; m_v = 0; m_ring = 0;
        exp_phase = 1'b0;
        reset = 1'b1;
        state = NORMAL_STATE; h_ptr = '0; v_ptr = '0; ringing = 1'b0; is_activated = 4'b0000;
        // time 12:34:56, digit 0 is the least significant
        t_dig[5] = 1; t_dig[4] = 2; t_dig[3] = 3; t_dig[2] = 4; t_dig[1] = 5; t_dig[0] = 6;
        for (int a = 0; a < ALARMS; a++)
            for (int i = 0; i < DIGITS; i++) a_dig[a][i] = $urandom_range(0, 9);
        // alarm 2 = 07:30:00
        a_dig[2][5] = 0; a_dig[2][4] = 7; a_dig[2][3] = 3;
        a_dig[2][2] = 0; a_dig[2][1] = 0; a_dig[2][0] = 0;
        apply_data();

        // reset held two cycles
        tick("reset0");
        tick("reset1");
        check("reset_blank", display_code, ALL_BLANK);

        // normal display of 12:34:56
        reset = 1'b0;
        tick("normal_first");
        check("normal_const", display_code,
              {6'h3F, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06});
        for (int i = 0; i < 6; i++) tick("normal");

        // time setting with cursor blink, then move cursor while hidden
        state = TIME_SETTING_STATE; h_ptr = 3'd2;
        for (int i = 0; i < 18; i++) tick("tset_h2");
        wait_hidden("tset_h2");
        h_ptr = 3'd3;
        for (int i = 0; i < 10; i++) tick("tset_h3");

        // alarm setting on slot 2
        state = ALARM_SETTING_STATE; v_ptr = 2'd2; is_activated = 4'b0100; h_ptr = 3'd1;
        tick("aset_first");
`ifdef LEADING_ZERO_BLANK_EN
        check("aset_const", display_code,
              {6'h0A, 6'h02, 6'h3F, 6'h07, 6'h03, 6'h00, 6'h00, 6'h00});
`else
        check("aset_const", display_code,
              {6'h0A, 6'h02, 6'h00, 6'h07, 6'h03, 6'h00, 6'h00, 6'h00});
`endif
        for (int i = 0; i < 10; i++) tick("aset");
        // slot 3 exists on the 4-slot build, not on the 3-slot build
        v_ptr = 2'd3;
        for (int i = 0; i < 6; i++) tick("aset_v3");
        check("aset_v3_blank3", code3, ALL_BLANK);

        // ringing in normal mode blinks the whole display
        state = NORMAL_STATE; is_activated = 4'b0010;
        tick("pre_ring");
        ringing = 1'b1;
        for (int i = 0; i < 18; i++) tick("ring");
        // ringing has no display effect in time setting
        state = TIME_SETTING_STATE; h_ptr = 3'd7;
        for (int i = 0; i < 12; i++) tick("ring_tset_h7");
        ringing = 1'b0;

        // undefined mode encoding
        state = state_t'(2'd3);
        for (int i = 0; i < 4; i++) tick("bad_state");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 15))
                0: state = state_t'($urandom_range(0, 3));
                1: h_ptr = 3'($urandom_range(0, 7));
                2: v_ptr = 2'($urandom_range(0, 3));
                3: ringing = ~ringing;
                4: is_activated = 4'($urandom_range(0, 15));
                5: begin
                    t_dig[$urandom_range(0, DIGITS-1)] = $urandom_range(0, 9);
                    a_dig[$urandom_range(0, ALARMS-1)][$urandom_range(0, DIGITS-1)] = $urandom_range(0, 9);
                    if ($urandom_range(0, 1) == 0) t_dig[DIGITS-1] = 0;
                    apply_data();
                end
                6: if ($urandom_range(0, 3) == 0) reset = 1'b1;
                default: ;
            endcase
            tick("rand");
            reset = 1'b0;
        end

        // reset while the display is hidden mid-ring
        state = NORMAL_STATE; ringing = 1'b0;
        tick("pre_ring2");
        ringing = 1'b1;
        tick("ring2");
        wait_hidden("ring2");
        reset = 1'b1;
        tick("reset_mid");
        check("reset_mid_blank", display_code, ALL_BLANK);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_frame_generator.md
DISPLAY_FRAME_GENERATOR -- requirements
Module: display_frame_generator

Interface
REQ-001 Parameters SHALL be, one per line:
- DIGITS, 6, number of BCD time digits.
- ALARMS, 4, number of alarm slots.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (>=1).
REQ-002 PW = max(1, $clog2(DIGITS)); VW = max(1, $clog2(ALARMS)).
REQ-003 Ports SHALL be, one per line:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- state  in  state_t  operating mode.
- h_ptr  in  PW  cursor digit index.
- v_ptr  in  VW  selected alarm index.
- time_data  in  DIGITS*4  BCD time digits, digit 0 at LSBs.
- alarm_data  in  ALARMS*DIGITS*4  BCD alarm times, alarm 0 at LSBs.
- is_activated  in  ALARMS  per-alarm enable flags.
- ringing  in  1  alarm currently sounding.
- display_code  out  (DIGITS+2)*6  per-position code, position 0 at LSBs.
- blink_phase  out  1  current blink phase; 1 = hidden.

Function
REQ-004 display_code SHALL be registered, one-cycle latency from any input change.
REQ-005 Position codes SHALL be BLANK = 6'h3F and ALARM_MARK = 6'h0A; a digit d SHALL be {2'b00, d}.
REQ-006 A blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap.
REQ-007 Counter and phase SHALL restart (count 0, phase 0) in the cycle after any change of state, h_ptr or v_ptr, or a rising edge of ringing.
REQ-008 NORMAL: position DIGITS+1 = ALARM_MARK if any is_activated bit is set, else BLANK; position DIGITS = BLANK; positions 0..DIGITS-1 = time digits.
REQ-009 NORMAL with ringing=1: all DIGITS+2 positions SHALL be BLANK while blink_phase=1, otherwise as REQ-008.
REQ-010 TIME_SET: positions DIGITS+1 and DIGITS = BLANK; digit h_ptr SHALL be BLANK while blink_phase=1; other digits show time.
REQ-011 ALARM_SET: position DIGITS+1 = ALARM_MARK if is_activated[v_ptr], else BLANK; position DIGITS = {zero-extended v_ptr}; digits show alarm v_ptr, with h_ptr blinking as REQ-010.
REQ-012 ringing SHALL be ignored outside NORMAL.
REQ-013 h_ptr >= DIGITS SHALL disable the digit blink; no position blanked.
REQ-014 v_ptr >= ALARMS in ALARM_SET SHALL drive all positions BLANK.
REQ-015 Any undefined state encoding SHALL drive all positions BLANK.

Reset
REQ-016 While reset=1 at a clock edge: display_code = all BLANK, blink counter = 0, blink_phase = 0, stored previous h_ptr/v_ptr/state/ringing cleared.
REQ-017 Reset SHALL take priority over every other event, including mid-blink and mid-ring.

Configuration
REQ-018 Macro LEADING_ZERO_BLANK_EN defined: in NORMAL and ALARM_SET, digit DIGITS-1 SHALL show BLANK when its value is 0; in TIME_SET it SHALL show 0.
REQ-019 Macro undefined: digit DIGITS-1 SHALL always show its value as REQ-008/011.

Structure
REQ-020 Package display_pkg SHALL hold state_t (NORMAL_STATE, TIME_SETTING_STATE, ALARM_SETTING_STATE), BLANK_CODE, ALARM_MARK_CODE and CODE_W = 6.
REQ-021 Sub-module blink_timer (parameter BLINK_DIV; ports clock, reset, restart, phase) SHALL implement REQ-006/007.

Verification (DIGITS=6, ALARMS=4, BLINK_DIV=4)
REQ-022 Reset held 2 cycles, then NORMAL, time 12:34:56, is_activated=0 -> next cycle positions 7..0 = 3F,3F,1,2,3,4,5,6.
REQ-023 TIME_SET, h_ptr=2 -> digit 2 alternates value/3F every 4 cycles; change h_ptr to 3 mid-hidden -> digit 3 visible for the next 4 cycles.
REQ-024 ALARM_SET, v_ptr=2, is_activated=4'b0100, alarm 2 = 07:30:00 -> position 7 = 0A, position 6 = 02, digits 0,7,3,0,0,0 (3F at index 5 with LEADING_ZERO_BLANK_EN).
REQ-025 NORMAL, ringing 0->1 -> all 8 positions visible 4 cycles, BLANK 4 cycles, repeating; ringing in TIME_SET -> no effect.
REQ-026 ALARM_SET, v_ptr=3 with ALARMS=3 -> all positions 3F; h_ptr=7 in TIME_SET -> no digit blinks.
REQ-027 Assert reset during blink_phase=1 -> display all 3F, blink_phase=0 the following cycle.
